// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - parametrised register file with post-reset clear sequencer and pending-write scoreboard
// Optional write-through bypass on the read ports: define REGFILE_BYPASS_EN.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    output logic              ready,
    input  logic              write,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic [ADDR_W-1:0] rdAddrA,
    output logic [DATA_W-1:0] rdDataA,
    input  logic [ADDR_W-1:0] rdAddrB,
    output logic [DATA_W-1:0] rdDataB,
    input  logic              rsvValid,
    input  logic [ADDR_W-1:0] rsvAddr,
    output logic              busyA,
    output logic              busyB,
    output logic [ADDR_W:0]   pendingCount
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   clr_ptr;
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_next;
    logic [ADDR_W:0]     count_next;
    logic                run;
    logic                wr_ok;
    logic                rsv_ok;
    logic                rd_ok_a;
    logic                rd_ok_b;
    logic                bypass_a;
    logic                bypass_b;

    assign run     = (state == ST_RUN);
    assign ready   = run;
    assign wr_ok   = (ZERO_REG == 0) || (wrAddr != '0);
    assign rsv_ok  = (ZERO_REG == 0) || (rsvAddr != '0);
    assign rd_ok_a = (ZERO_REG == 0) || (rdAddrA != '0);
    assign rd_ok_b = (ZERO_REG == 0) || (rdAddrB != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_next;
        end
    end

    // Leave CLEAR on the same edge that zeroes the last register.
    always_comb begin
        state_next = state;
        if ((state == ST_CLEAR) && (&clr_ptr)) begin
            state_next = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clr_ptr <= '0;
        end else if (!run) begin
            clr_ptr <= clr_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (!run) begin
                regs[clr_ptr] <= '0;
            end else if (write && wr_ok) begin
                regs[wrAddr] <= wrData;
            end
        end
    end

    // Reserve is applied after the write so a same-cycle new producer keeps the bit set.
    always_comb begin
        pending_next = pending;
        if (run) begin
            if (write && wr_ok) begin
                pending_next[wrAddr] = 1'b0;
            end
            if (rsvValid && rsv_ok) begin
                pending_next[rsvAddr] = 1'b1;
            end
        end
    end

    always_comb begin
        count_next = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            count_next = count_next + (ADDR_W+1)'(pending_next[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending      <= '0;
            pendingCount <= '0;
        end else begin
            pending      <= pending_next;
            pendingCount <= count_next;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign bypass_a = run && write && wr_ok && (wrAddr == rdAddrA);
    assign bypass_b = run && write && wr_ok && (wrAddr == rdAddrB);
`else
    assign bypass_a = 1'b0;
    assign bypass_b = 1'b0;
`endif

    assign rdDataA = (!run || !rd_ok_a) ? '0 : (bypass_a ? wrData : regs[rdAddrA]);
    assign rdDataB = (!run || !rd_ok_b) ? '0 : (bypass_b ? wrData : regs[rdAddrB]);
    assign busyA   = run && pending[rdAddrA] && !bypass_a;
    assign busyB   = run && pending[rdAddrB] && !bypass_b;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - randomized self-checking bench for regfile_scoreboard against an array-based reference model
module tb_regfile_scoreboard;

    logic        clk;
    logic        reset;
    logic        ready;
    logic        write;
    logic [4:0]  wrAddr;
    logic [31:0] wrData;
    logic [4:0]  rdAddrA;
    logic [31:0] rdDataA;
    logic [4:0]  rdAddrB;
    logic [31:0] rdDataB;
    logic        rsvValid;
    logic [4:0]  rsvAddr;
    logic        busyA;
    logic        busyB;
    logic [5:0]  pendingCount;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [32];
    bit          m_pend [32];
    bit          m_clear;
    int          m_clr_idx;

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .clk(clk), .reset(reset), .ready(ready),
        .write(write), .wrAddr(wrAddr), .wrData(wrData),
        .rdAddrA(rdAddrA), .rdDataA(rdDataA),
        .rdAddrB(rdAddrB), .rdDataB(rdDataB),
        .rsvValid(rsvValid), .rsvAddr(rsvAddr),
        .busyA(busyA), .busyB(busyB), .pendingCount(pendingCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_edge();
        if (reset) begin
            m_clear   = 1'b1;
            m_clr_idx = 0;
            for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        end else if (m_clear) begin
            m_regs[m_clr_idx] = 32'h0;
            m_clr_idx++;
            if (m_clr_idx == 32) m_clear = 1'b0;
        end else begin
            if (write && wrAddr != 0) begin
                m_regs[wrAddr] = wrData;
                m_pend[wrAddr] = 1'b0;
            end
            if (rsvValid && rsvAddr != 0) m_pend[rsvAddr] = 1'b1;
        end
    endfunction

    function automatic bit bypass_hit(logic [4:0] a);
`ifdef REGFILE_BYPASS_EN
        return !m_clear && write && wrAddr != 0 && wrAddr == a;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] exp_rd(logic [4:0] a);
        if (m_clear || a == 0) return 32'h0;
        if (bypass_hit(a)) return wrData;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(logic [4:0] a);
        if (m_clear || bypass_hit(a)) return 1'b0;
        return m_pend[a];
    endfunction

    function automatic logic [5:0] exp_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_pend[i]);
        return 6'(n);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        write = 1'b0; rsvValid = 1'b0; reset = 1'b0;
    endtask

    task automatic wait_ready(input string tag, input int want_low);
        int low = 0;
        int limit = 100;
        while (limit > 0) begin
            @(negedge clk);
            if (ready === 1'b1) break;
            checks++;
            if (rdDataA !== 32'h0 || busyA !== 1'b0) begin
                errors++;
                $display("FAIL %s_clear_read: rdDataA=%h busyA=%b required 0/0", tag, rdDataA, busyA);
            end
            low++;
            limit--;
            tick();
        end
        checks++;
        if (low !== want_low || ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_low_cycles: got %0d (ready=%b) required %0d", tag, low, ready, want_low);
        end
        checks++;
        if (pendingCount !== 6'd0) begin
            errors++;
            $display("FAIL %s_count_after_clear: got %0d required 0", tag, pendingCount);
        end
    endtask

    task automatic check_all_zero(input string tag);
        idle();
        for (int i = 0; i < 32; i += 2) begin
            rdAddrA = 5'(i); rdAddrB = 5'(i + 1);
            @(negedge clk);
            checks++;
            if (rdDataA !== 32'h0 || rdDataB !== 32'h0) begin
                errors++;
                $display("FAIL %s_zero_r%0d: got %h/%h required 0/0", tag, i, rdDataA, rdDataB);
            end
            tick();
        end
    endtask

    task automatic test_reset();
        idle();
        write = 1'b1; wrAddr = 5'd3; wrData = 32'd5; rdAddrA = 5'd3; rdAddrB = 5'd0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wait_ready("reset", 32);
        check_all_zero("reset");
    endtask

    task automatic test_write_read();
        idle();
        write = 1'b1; wrAddr = 5'd7; wrData = 32'hDEAD_BEEF;
        tick();
        write = 1'b0; rdAddrA = 5'd7;
        @(negedge clk);
        checks++;
        if (rdDataA !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_r7: got %h required deadbeef", rdDataA);
        end
        write = 1'b1; wrAddr = 5'd0; wrData = 32'h1234;
        tick();
        write = 1'b0; rdAddrB = 5'd0;
        @(negedge clk);
        checks++;
        if (rdDataB !== 32'h0) begin
            errors++;
            $display("FAIL write_r0: got %h required 0", rdDataB);
        end
        tick();
    endtask

    task automatic test_reserve();
        idle();
        rsvValid = 1'b1; rsvAddr = 5'd4;
        tick();
        rsvAddr = 5'd5;
        tick();
        rsvValid = 1'b0; rdAddrA = 5'd4;
        @(negedge clk);
        checks++;
        if (busyA !== 1'b1 || pendingCount !== 6'd2) begin
            errors++;
            $display("FAIL reserve_two: busyA=%b count=%0d required 1/2", busyA, pendingCount);
        end
        tick();
        write = 1'b1; wrAddr = 5'd4; wrData = 32'd9;
        tick();
        write = 1'b0;
        @(negedge clk);
        checks++;
        if (busyA !== 1'b0 || pendingCount !== 6'd1 || rdDataA !== 32'd9) begin
            errors++;
            $display("FAIL reserve_release: busyA=%b count=%0d data=%h required 0/1/9", busyA, pendingCount, rdDataA);
        end
        tick();
    endtask

    task automatic test_same_cycle();
        idle();
        write = 1'b1; wrAddr = 5'd6; wrData = 32'd1; rsvValid = 1'b1; rsvAddr = 5'd6;
        tick();
        idle();
        rdAddrA = 5'd6;
        @(negedge clk);
        checks++;
        if (rdDataA !== 32'd1 || busyA !== 1'b1 || pendingCount !== exp_count()) begin
            errors++;
            $display("FAIL same_cycle_r6: data=%h busy=%b count=%0d required 1/1/%0d", rdDataA, busyA, pendingCount, exp_count());
        end
        tick();
    endtask

    task automatic test_bypass();
        idle();
        rsvValid = 1'b1; rsvAddr = 5'd8;
        tick();
        idle();
        write = 1'b1; wrAddr = 5'd8; wrData = 32'h55; rdAddrA = 5'd8; rdAddrB = 5'd8;
        @(negedge clk);
        checks++;
`ifdef REGFILE_BYPASS_EN
        if (rdDataA !== 32'h55 || busyA !== 1'b0 || rdDataB !== 32'h55 || busyB !== 1'b0) begin
            errors++;
            $display("FAIL bypass_r8: A=%h/%b B=%h/%b required 55/0", rdDataA, busyA, rdDataB, busyB);
        end
`else
        if (rdDataA !== 32'h0 || busyA !== 1'b1 || rdDataB !== 32'h0 || busyB !== 1'b1) begin
            errors++;
            $display("FAIL bypass_r8: A=%h/%b B=%h/%b required 0/1", rdDataA, busyA, rdDataB, busyB);
        end
`endif
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (rdDataA !== 32'h55 || busyA !== 1'b0) begin
            errors++;
            $display("FAIL bypass_after_r8: data=%h busy=%b required 55/0", rdDataA, busyA);
        end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset    = 1'b0;
            write    = 1'($urandom_range(0, 1));
            wrAddr   = 5'($urandom_range(0, 31));
            wrData   = $urandom;
            rsvValid = 1'($urandom_range(0, 2) != 0);
            rsvAddr  = 5'($urandom_range(0, 31));
            rdAddrA  = ($urandom_range(0, 3) == 0) ? wrAddr : 5'($urandom_range(0, 31));
            rdAddrB  = ($urandom_range(0, 3) == 0) ? rsvAddr : 5'($urandom_range(0, 31));
            @(negedge clk);
            checks++;
            if (rdDataA !== exp_rd(rdAddrA) || rdDataB !== exp_rd(rdAddrB) ||
                busyA !== exp_busy(rdAddrA) || busyB !== exp_busy(rdAddrB) ||
                pendingCount !== exp_count()) begin
                errors++;
                $display("FAIL random_%0d: A[%0d]=%h/%b B[%0d]=%h/%b cnt=%0d required %h/%b %h/%b cnt=%0d",
                         n, rdAddrA, rdDataA, busyA, rdAddrB, rdDataB, busyB, pendingCount,
                         exp_rd(rdAddrA), exp_busy(rdAddrA), exp_rd(rdAddrB), exp_busy(rdAddrB), exp_count());
            end
            tick();
        end
        idle();
        @(negedge clk);
        checks++;
        if (pendingCount !== exp_count()) begin
            errors++;
            $display("FAIL random_final_count: got %0d required %0d", pendingCount, exp_count());
        end
    endtask

    task automatic test_reset_mid_clear();
        idle();
        rdAddrA = 5'd1; rdAddrB = 5'd2;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        @(negedge clk);
        checks++;
        if (ready !== 1'b0 || pendingCount !== 6'd0) begin
            errors++;
            $display("FAIL mid_clear_state: ready=%b count=%0d required 0/0", ready, pendingCount);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wait_ready("midclr", 32);
        check_all_zero("midclr");
    endtask

    initial begin
        idle();
        wrAddr = '0; wrData = '0; rsvAddr = '0; rdAddrA = '0; rdAddrB = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_write_read();
        test_reserve();
        test_same_cycle();
        test_bypass();
        test_random();
        test_reset_mid_clear();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised successor to the pipeline's 32x32 register file.
- Generalised in data width and register count.
- Adds a hardware clear sequencer after reset, so no initial-value preload is needed.
- Adds a pending-write scoreboard so the decode stage can detect RAW hazards against in-flight producers.
- Sits between decode (reads, reserve) and writeback (write).

Parameters:
DATA_W 32 register width in bits
ADDR_W 5 register address width; NUM_REGS = 2**ADDR_W
ZERO_REG 1 when 1, register 0 reads 0, ignores writes and is never pending

Ports:
clk in 1 clock
reset in 1 synchronous active-high reset
ready out 1 high once clear sequence is complete
write in 1 writeback write enable
wrAddr in ADDR_W writeback address
wrData in DATA_W writeback data
rdAddrA in ADDR_W read port A address
rdDataA out DATA_W read port A data (combinational)
rdAddrB in ADDR_W read port B address
rdDataB out DATA_W read port B data (combinational)
rsvValid in 1 decode reserves a destination register
rsvAddr in ADDR_W destination being reserved
busyA out 1 register rdAddrA has a pending write
busyB out 1 register rdAddrB has a pending write
pendingCount out ADDR_W+1 number of pending registers (registered)

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset: on the next posedge, enter CLEAR with clrPtr=0. Also ready=0, all pending bits=0, pendingCount=0.
- FSM state CLEAR:
  - Each cycle write 0 to regfile[clrPtr] and increment clrPtr.
  - The cycle clrPtr==NUM_REGS-1 is written, go to RUN. Clear takes exactly NUM_REGS cycles; ready rises on the following edge.
  - write and rsvValid are ignored.
  - rdDataA/B=0; busyA/B=0.
- FSM state RUN: ready=1; stays in RUN until reset.
- Reset asserted in any state, including mid-CLEAR, restarts CLEAR from clrPtr=0.
- Write (RUN): on posedge, if write is high, regfile[wrAddr] <= wrData and pending[wrAddr] <= 0. Exception: when ZERO_REG=1 and wrAddr==0, nothing changes.
- Reserve (RUN): on posedge, if rsvValid is high, pending[rsvAddr] <= 1. Exception: when ZERO_REG=1 and rsvAddr==0, nothing changes.
- Simultaneous write and reserve to the same address: data is written and the pending bit ends set (the new producer wins).
- Reads: rdDataX = regfile[rdAddrX], forced to 0 when ZERO_REG=1 and rdAddrX==0. busyX = pending[rdAddrX], subject to the bypass rule below.
- pendingCount: popcount of the next pending vector, registered, so it matches the pending bits one cycle after the update. Maximum value is NUM_REGS-1 with ZERO_REG=1, NUM_REGS otherwise.
- Writing to a non-pending register is legal; pending stays 0.
- Reserving an already-pending register is legal; the bit stays 1 and the count is unchanged.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: in RUN, when write is high, wrAddr==rdAddrX and the target is writable:
  - rdDataX = wrData in the same cycle (write-through);
  - busyX = 0 that cycle.
- Undefined: the read returns the old value; the new value is visible the cycle after the edge; busyX stays high until the edge that clears it.

Test Plan:
1. Reset 1 cycle then release, with write=1, wrAddr=3, wrData=5 driven throughout → ready low for exactly 32 cycles. All 32 reads return 0. The write during CLEAR leaves r3=0.
2. RUN: write r7=0xDEAD_BEEF, next cycle rdAddrA=7 → rdDataA=0xDEADBEEF. Write r0=0x1234, rdAddrB=0 → rdDataB=0.
3. Reserve r4, r5 on consecutive cycles, rdAddrA=4 → busyA=1 and pendingCount reaches 2. Write r4=9 → busyA=0 next cycle, pendingCount=1.
4. Same cycle: write r6=1 and rsvValid with rsvAddr=6 → r6=1, pending[6]=1, busy remains.
5. Write r8=0x55 with rdAddrA=8 in the same cycle → with REGFILE_BYPASS_EN, rdDataA=0x55 and busyA=0 that cycle. Without it, rdDataA equals the old value (0 after clear).
6. Reset asserted at clear cycle 10 → clear restarts. ready rises 32 cycles after reset deasserts. pendingCount=0.
